pci_target_port: RTL and testbench
==================================

# pci_target_port

- Bus-side target stage that consumes the transactions produced by a PCI-style initiator device on the shared FRAME/IRDY/AD/CBE bus.
- Decodes the address phase against its base address and claims matching cycles with DEVSEL/TRDY.
- Stores write bursts into a local word memory and returns read bursts from it.
- All bus control signals are active-low. Tri-state drive is split into value/enable pairs, so the top level builds the inout.

## Interface
- BASE_ADDR, 32'h0000_0010 — decode base; AD[31:4] must equal BASE_ADDR[31:4].
- DEPTH, 16 — words in local memory; index = AD[3:0] mod DEPTH.
- CLK in 1 — single clock; everything samples on posedge.
- RESET in 1 — synchronous, active-high.
- FRAME in 1 — initiator frame, active-low.
- IRDY in 1 — initiator ready, active-low.
- CBE in 4 — command in the address phase (4'b0010 read, 4'b0011 write); byte enables in data phases (active-low).
- AD_IN in 32 — bus AD sampled.
- AD_OUT out 32 — read data value.
- AD_OE out 1 — enable for AD_OUT onto the bus.
- TRDY_OUT out 1 — target ready value.
- DEVSEL_OUT out 1 — device select value.
- TGT_OE out 1 — enable for TRDY_OUT and DEVSEL_OUT.
- DONE out 1 — one-cycle pulse after the last data phase of a claimed transaction.

## Operation
- States: IDLE, WR_DATA, RD_TA, RD_DATA, TURN, WAIT_IDLE.
- IDLE: on a posedge with FRAME==0 and FRAME==1 on the previous edge, this is the address phase.
  - Hit: AD_IN[31:4]==BASE_ADDR[31:4] and CBE is 0010 or 0011. Latch idx=AD_IN[3:0] mod DEPTH.
  - Go to WR_DATA (write) or RD_TA (read). Assert TGT_OE=1 and DEVSEL_OUT=0.
  - Miss or any other command: go to WAIT_IDLE, no outputs driven.
- WR_DATA: TRDY_OUT=0.
  - Each edge with IRDY==0 && TRDY_OUT==0 is a transfer.
  - For each byte b where CBE[b]==0, write mem[idx] byte b from AD_IN. Then idx=(idx+1) mod DEPTH.
- RD_TA: one turnaround cycle, TRDY_OUT=1. Then AD_OE=1, AD_OUT=mem[idx], go to RD_DATA.
- RD_DATA: TRDY_OUT=0.
  - On each transfer, idx increments and AD_OUT is registered to mem[idx+1 mod DEPTH].
  - Byte enables are ignored on reads.
- Last data phase: the transfer where FRAME==1. Go to TURN and drive TRDY_OUT=1 and DEVSEL_OUT=1 with TGT_OE still 1. AD_OE drops to 0 at this same edge.
- TURN: lasts one cycle. Then TGT_OE=0, DONE=1 for that cycle, next state IDLE.
- Master abort: in any data state, FRAME==1 and IRDY==1 together means go to TURN with no write. DONE still pulses.
- WAIT_IDLE: stay until FRAME==1 and IRDY==1, then go to IDLE.
- Index wrap: at DEPTH-1 the index returns to 0. No disconnect is issued.

## Timing
- Reset values: AD_OUT=0, AD_OE=0, TRDY_OUT=1, DEVSEL_OUT=1, TGT_OE=0, DONE=0, state IDLE, idx=0.
- Memory is not cleared by RESET.
- RESET mid-transaction: all enables drop at the next edge and the bus is released immediately.
- After reset, a new address phase still requires FRAME to go 1 then 0.
- Address phase at edge A:
  - DEVSEL_OUT=0 visible after A.
  - Write: TRDY_OUT=0 after A, so the first write transfer is possible at A+1.
  - Read: TRDY_OUT=0 and AD_OE=1 after A+1, so the first read transfer is possible at A+2.
- Zero wait states thereafter; the burst rate is bounded only by IRDY.
- IRDY==1 during a data phase: hold. No transfer, no idx change, AD_OUT stable.
- Write data written at edge T is readable by a read address phase at T+1 or later.

## Configuration
- PCI_TGT_WAIT_EN defined: one target wait state is inserted on the first data phase of every claimed transaction.
  - TRDY_OUT stays 1 for one extra cycle.
  - First transfer is no earlier than A+2 (write) or A+3 (read).
- Undefined: timing exactly as stated above.

## Test plan
- Write, 3 words to 32'h0000_0010, CBE=0000, data AAAA_AAAA/BBBB_BBBB/CCCC_CCCC, FRAME high on word 3 -> DEVSEL=0 at A+1, mem[0..2] hold the three words, TURN for one cycle, DONE pulse, TGT_OE=0.
- Read, 3 words from 32'h0000_0010 after the write above -> AD_OE=1 from A+2, AD returns AAAA_AAAA/BBBB_BBBB/CCCC_CCCC on consecutive transfers, AD_OE=0 after the last one.
- Address 32'h0000_0100 -> no DEVSEL, all OE=0, block returns to IDLE once FRAME=IRDY=1.
- Byte-enable write CBE=1110 data 1234_5678 to idx 3, whose prior value is FFFF_FFFF -> mem[3]=FFFF_FF78.
- 2-word write starting at idx 15 -> data lands in mem[15] then mem[0].
- RESET asserted during RD_DATA -> AD_OE=0, TGT_OE=0, TRDY_OUT=1 at the next edge; a subsequent read of the same address returns the unchanged memory contents.

Source files
------------

// File: rtl/pci_target_port.sv
// pci_target_port: PCI-style bus target.
// Claims address phases that decode to BASE_ADDR, stores write bursts into a
// local word memory and returns read bursts from it. All bus controls are
// active-low; tri-state drive is presented as value/enable pairs.
// Optional feature macro: PCI_TGT_WAIT_EN inserts one target wait state on the
// first data phase of every claimed transaction.
//
// Handshake: a data transfer happens on a posedge where IRDY==0 and
// TRDY_OUT==0; the last transfer is the one sampled with FRAME==1, and
// FRAME==1 with IRDY==1 during a data state is a master abort.
module pci_target_port #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0010,
    parameter int          DEPTH     = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FRAME,
    input  logic        IRDY,
    input  logic [3:0]  CBE,
    input  logic [31:0] AD_IN,
    output logic [31:0] AD_OUT,
    output logic        AD_OE,
    output logic        TRDY_OUT,
    output logic        DEVSEL_OUT,
    output logic        TGT_OE,
    output logic        DONE
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CMD_RD = 4'b0010;
    localparam logic [3:0] CMD_WR = 4'b0011;

`ifdef PCI_TGT_WAIT_EN
    // TRDY value presented on entry to the first data phase (1 = wait state).
    localparam logic FIRST_TRDY = 1'b1;
`else
    localparam logic FIRST_TRDY = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_DATA   = 3'd1,
        RD_TA     = 3'd2,
        RD_DATA   = 3'd3,
        TURN      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            frame_q;
    logic [31:0]     mem [DEPTH];

    logic            addr_phase;
    logic            hit;
    logic            xfer;
    logic            abort;
    logic            wr_en;
    logic [IW-1:0]   idx_start;
    logic [IW-1:0]   idx_inc;

    // Decode of the current bus cycle and the wrapped index arithmetic.
    always_comb begin
        addr_phase = (state == IDLE) && !FRAME && frame_q;
        hit        = (AD_IN[31:4] == BASE_ADDR[31:4]) && ((CBE == CMD_RD) || (CBE == CMD_WR));
        xfer       = !IRDY && !TRDY_OUT;
        abort      = FRAME && IRDY;
        wr_en      = !RESET && (state == WR_DATA) && xfer;
        idx_start  = IW'(32'(AD_IN[3:0]) % 32'(DEPTH));
        if (int'(idx) == DEPTH - 1) begin
            idx_inc = '0;
        end else begin
            idx_inc = idx + IW'(1);
        end
    end

    // Word memory with per-byte write enables; not cleared by reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (!CBE[b]) begin
                    mem[idx][8*b +: 8] <= AD_IN[8*b +: 8];
                end
            end
        end
    end

    // Target FSM with all bus-facing outputs registered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            idx        <= '0;
            frame_q    <= 1'b0;   // forces FRAME to be seen high before a new claim
            AD_OUT     <= '0;
            AD_OE      <= 1'b0;
            TRDY_OUT   <= 1'b1;
            DEVSEL_OUT <= 1'b1;
            TGT_OE     <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            frame_q <= FRAME;
            DONE    <= 1'b0;
            case (state)
                IDLE: begin
                    if (addr_phase) begin
                        if (hit) begin
                            idx        <= idx_start;
                            TGT_OE     <= 1'b1;
                            DEVSEL_OUT <= 1'b0;
                            if (CBE == CMD_WR) begin
                                state    <= WR_DATA;
                                TRDY_OUT <= FIRST_TRDY;
                            end else begin
                                state    <= RD_TA;
                                TRDY_OUT <= 1'b1;
                            end
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end
                end
                WR_DATA: begin
                    if (abort) begin
                        state      <= TURN;
                        TRDY_OUT   <= 1'b1;
                        DEVSEL_OUT <= 1'b1;
                    end else if (TRDY_OUT) begin
                        TRDY_OUT <= 1'b0;   // end of the optional wait state
                    end else if (xfer) begin
                        idx <= idx_inc;
                        if (FRAME) begin
                            state      <= TURN;
                            TRDY_OUT   <= 1'b1;
                            DEVSEL_OUT <= 1'b1;
                        end
                    end
                end
                RD_TA: begin
                    if (abort) begin
                        state      <= TURN;
                        TRDY_OUT   <= 1'b1;
                        DEVSEL_OUT <= 1'b1;
                    end else begin
                        state    <= RD_DATA;
                        AD_OE    <= 1'b1;
                        AD_OUT   <= mem[idx];
                        TRDY_OUT <= FIRST_TRDY;
                    end
                end
                RD_DATA: begin
                    if (abort) begin
                        state      <= TURN;
                        AD_OE      <= 1'b0;
                        TRDY_OUT   <= 1'b1;
                        DEVSEL_OUT <= 1'b1;
                    end else if (TRDY_OUT) begin
                        TRDY_OUT <= 1'b0;
                    end else if (xfer) begin
                        idx <= idx_inc;
                        if (FRAME) begin
                            state      <= TURN;
                            AD_OE      <= 1'b0;
                            TRDY_OUT   <= 1'b1;
                            DEVSEL_OUT <= 1'b1;
                        end else begin
                            AD_OUT <= mem[idx_inc];
                        end
                    end
                end
                TURN: begin
                    state  <= IDLE;
                    TGT_OE <= 1'b0;
                    DONE   <= 1'b1;
                end
                WAIT_IDLE: begin
                    if (FRAME && IRDY) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_target_port.sv
// tb_pci_target_port: directed vector bench for pci_target_port (default build).
// Each vector drives one cycle of bus inputs and states the registered outputs
// expected after the following posedge. Control outputs are packed as
// {AD_OE, TRDY_OUT, DEVSEL_OUT, TGT_OE, DONE}.
module tb_pci_target_port;

    logic        CLK;
    logic        RESET;
    logic        FRAME;
    logic        IRDY;
    logic [3:0]  CBE;
    logic [31:0] AD_IN;
    logic [31:0] AD_OUT;
    logic        AD_OE;
    logic        TRDY_OUT;
    logic        DEVSEL_OUT;
    logic        TGT_OE;
    logic        DONE;

    pci_target_port #(
        .BASE_ADDR(32'h0000_0010),
        .DEPTH(16)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .FRAME(FRAME),
        .IRDY(IRDY),
        .CBE(CBE),
        .AD_IN(AD_IN),
        .AD_OUT(AD_OUT),
        .AD_OE(AD_OE),
        .TRDY_OUT(TRDY_OUT),
        .DEVSEL_OUT(DEVSEL_OUT),
        .TGT_OE(TGT_OE),
        .DONE(DONE)
    );

    // Clock / reset block.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    localparam logic [3:0] RD = 4'b0010;
    localparam logic [3:0] WR = 4'b0011;

    // Expected control patterns {AD_OE, TRDY_OUT, DEVSEL_OUT, TGT_OE, DONE}.
    localparam logic [4:0] IDL = 5'b01100;  // bus released
    localparam logic [4:0] CLW = 5'b00010;  // write claimed, TRDY asserted
    localparam logic [4:0] RTA = 5'b01010;  // read claimed, turnaround
    localparam logic [4:0] RDD = 5'b10010;  // read data phase
    localparam logic [4:0] TRN = 5'b01110;  // turnaround after last phase
    localparam logic [4:0] DN  = 5'b01101;  // released, DONE pulse

    typedef struct {
        logic        rst;
        logic        frame;
        logic        irdy;
        logic [3:0]  cbe;
        logic [31:0] ad;
        logic [4:0]  e_ctl;
        logic        chk_ad;
        logic [31:0] e_ad;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic add(input logic rst, input logic frame, input logic irdy,
                       input logic [3:0] cbe, input logic [31:0] ad,
                       input logic [4:0] e_ctl, input logic chk_ad, input logic [31:0] e_ad);
        vec_t v;
        v.rst = rst; v.frame = frame; v.irdy = irdy; v.cbe = cbe; v.ad = ad;
        v.e_ctl = e_ctl; v.chk_ad = chk_ad; v.e_ad = e_ad;
        vecs.push_back(v);
    endtask

    // Driver: apply one cycle of inputs and wait until just after the edge.
    task automatic drive(input logic rst, input logic frame, input logic irdy,
                         input logic [3:0] cbe, input logic [31:0] ad);
        RESET = rst; FRAME = frame; IRDY = irdy; CBE = cbe; AD_IN = ad;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_ctl(input string name, input logic [4:0] e_ctl);
        logic [4:0] got;
        got = {AD_OE, TRDY_OUT, DEVSEL_OUT, TGT_OE, DONE};
        checks++;
        if (got !== e_ctl) begin
            failures++;
            $display("FAIL %s ctl got=%b exp=%b", name, got, e_ctl);
        end
    endtask

    task automatic check_ad(input string name, input logic [31:0] e_ad);
        checks++;
        if (AD_OUT !== e_ad) begin
            failures++;
            $display("FAIL %s ad got=%h exp=%h", name, AD_OUT, e_ad);
        end
    endtask

    initial begin
        int cyc;
        RESET = 1'b1; FRAME = 1'b1; IRDY = 1'b1; CBE = 4'h0; AD_IN = '0;

        // Reset values.
        add(1, 1, 1, 4'h0, 32'h0, IDL, 1, 32'h0);
        add(1, 1, 1, 4'h0, 32'h0, IDL, 1, 32'h0);
        // 3-word write to idx 0..2.
        add(0, 1, 1, 4'h0, 32'h0,         IDL, 1, 32'h0);
        add(0, 0, 1, WR,   32'h0000_0010, CLW, 0, 32'h0);
        add(0, 0, 0, 4'h0, 32'hAAAA_AAAA, CLW, 0, 32'h0);
        add(0, 0, 0, 4'h0, 32'hBBBB_BBBB, CLW, 0, 32'h0);
        add(0, 1, 0, 4'h0, 32'hCCCC_CCCC, TRN, 0, 32'h0);
        add(0, 1, 1, 4'h0, 32'h0,         DN,  0, 32'h0);
        add(0, 1, 1, 4'h0, 32'h0,         IDL, 0, 32'h0);
        // 3-word read back, with one initiator hold cycle.
        add(0, 0, 1, RD,   32'h0000_0010, RTA, 0, 32'h0);
        add(0, 0, 0, 4'h0, 32'h0,         RDD, 1, 32'hAAAA_AAAA);
        add(0, 0, 0, 4'h0, 32'h0,         RDD, 1, 32'hBBBB_BBBB);
        add(0, 0, 1, 4'h0, 32'h0,         RDD, 1, 32'hBBBB_BBBB);
        add(0, 0, 0, 4'h0, 32'h0,         RDD, 1, 32'hCCCC_CCCC);
        add(0, 1, 0, 4'h0, 32'h0,         TRN, 0, 32'h0);
        add(0, 1, 1, 4'h0, 32'h0,         DN,  0, 32'h0);
        // Address miss: ignored until FRAME=IRDY=1, then a claim proves IDLE.
        add(0, 0, 1, WR,   32'h0000_0100, IDL, 0, 32'h0);
        add(0, 0, 0, 4'h0, 32'h0,         IDL, 0, 32'h0);
        add(0, 1, 0, 4'h0, 32'h0,         IDL, 0, 32'h0);
        add(0, 1, 1, 4'h0, 32'h0,         IDL, 0, 32'h0);
        add(0, 0, 1, RD,   32'h0000_0010, RTA, 0, 32'h0);
        add(0, 1, 1, 4'h0, 32'h0,         TRN, 0, 32'h0);   // master abort
        add(0, 1, 1, 4'h0, 32'h0,         DN,  0, 32'h0);
        // Unsupported command at a matching address.
        add(0, 0, 1, 4'b0110, 32'h0000_0010, IDL, 0, 32'h0);
        add(0, 1, 1, 4'h0,    32'h0,         IDL, 0, 32'h0);
        // Master abort of a write: idx 2 must keep CCCC_CCCC.
        add(0, 0, 1, WR,   32'h0000_0012, CLW, 0, 32'h0);
        add(0, 1, 1, 4'h0, 32'hDEAD_BEEF, TRN, 0, 32'h0);
        add(0, 1, 1, 4'h0, 32'h0,         DN,  0, 32'h0);
        // Byte-enable write into idx 3 holding FFFF_FFFF.
        add(0, 0, 1, WR,      32'h0000_0013, CLW, 0, 32'h0);
        add(0, 1, 0, 4'h0,    32'hFFFF_FFFF, TRN, 0, 32'h0);
        add(0, 1, 1, 4'h0,    32'h0,         DN,  0, 32'h0);
        add(0, 0, 1, WR,      32'h0000_0013, CLW, 0, 32'h0);
        add(0, 1, 0, 4'b1110, 32'h1234_5678, TRN, 0, 32'h0);
        add(0, 1, 1, 4'h0,    32'h0,         DN,  0, 32'h0);
        add(0, 0, 1, RD,      32'h0000_0013, RTA, 0, 32'h0);
        add(0, 1, 0, 4'hF,    32'h0,         RDD, 1, 32'hFFFF_FF78);
        add(0, 1, 0, 4'h0,    32'h0,         TRN, 0, 32'h0);
        add(0, 1, 1, 4'h0,    32'h0,         DN,  0, 32'h0);
        // Index wrap: write idx 15 then 0, read them back.
        add(0, 0, 1, WR,   32'h0000_001F, CLW, 0, 32'h0);
        add(0, 0, 0, 4'h0, 32'h1111_0001, CLW, 0, 32'h0);
        add(0, 1, 0, 4'h0, 32'h2222_0002, TRN, 0, 32'h0);
        add(0, 1, 1, 4'h0, 32'h0,         DN,  0, 32'h0);
        add(0, 0, 1, RD,   32'h0000_001F, RTA, 0, 32'h0);
        add(0, 0, 0, 4'h0, 32'h0,         RDD, 1, 32'h1111_0001);
        add(0, 0, 0, 4'h0, 32'h0,         RDD, 1, 32'h2222_0002);
        add(0, 1, 0, 4'h0, 32'h0,         TRN, 0, 32'h0);
        add(0, 1, 1, 4'h0, 32'h0,         DN,  0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(vecs[i].rst, vecs[i].frame, vecs[i].irdy, vecs[i].cbe, vecs[i].ad);
            check_ctl(nm, vecs[i].e_ctl);
            if (vecs[i].chk_ad) check_ad(nm, vecs[i].e_ad);
        end

        // Reset in the middle of a read burst from idx 1.
        drive(0, 0, 1, RD, 32'h0000_0011);   check_ctl("rst_rd_claim", RTA);
        drive(0, 0, 0, 4'h0, 32'h0);         check_ad("rst_rd_w0", 32'hBBBB_BBBB);
        drive(0, 0, 0, 4'h0, 32'h0);         check_ad("rst_rd_w1", 32'hCCCC_CCCC);
        drive(1, 0, 0, 4'h0, 32'h0);         check_ctl("rst_mid_ctl", IDL);
        check_ad("rst_mid_ad", 32'h0);
        // FRAME held low across reset must not be taken as an address phase.
        drive(0, 0, 1, RD, 32'h0000_0011);   check_ctl("rst_no_claim", IDL);
        drive(0, 1, 1, 4'h0, 32'h0);         check_ctl("rst_idle", IDL);

        // Re-read after reset: memory contents unchanged.
        exp_q.push_back(32'hBBBB_BBBB);
        exp_q.push_back(32'hCCCC_CCCC);
        drive(0, 0, 1, RD, 32'h0000_0011);   check_ctl("rerd_claim", RTA);
        drive(0, 0, 0, 4'h0, 32'h0);         check_ctl("rerd_d0", RDD);
        check_ad("rerd_d0", exp_q.pop_front());
        drive(0, 0, 0, 4'h0, 32'h0);         check_ad("rerd_d1", exp_q.pop_front());
        drive(0, 1, 0, 4'h0, 32'h0);         check_ctl("rerd_last", TRN);

        // DONE must pulse on the cycle after TURN; bounded wait.
        cyc = 0;
        do begin
            drive(0, 1, 1, 4'h0, 32'h0);
            cyc++;
        end while (!DONE && cyc < 4);
        checks++;
        if (cyc != 1 || DONE !== 1'b1) begin
            failures++;
            $display("FAIL rerd_done cycles got=%0d exp=1 done=%b", cyc, DONE);
        end
        drive(0, 1, 1, 4'h0, 32'h0);         check_ctl("rerd_release", IDL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
